// File: rtl/nock_image_loader_if.sv
// -----------------------------------------------------------------------------
// nock_image_loader_if
//   Groups the signals of the noun-image loader that are not clock or reset.
//   These are the load control, the word stream, the memory request port and
//   the status outputs.
//
//   Modports
//     master : environment side. It drives load_start/base_addr, the stream
//              and mem_ready, and it observes everything else.
//     slave  : loader side (nock_image_loader).
//
//   Signals
//     load_start, base_addr           load control (in to the loader)
//     s_valid, s_data, s_last         word stream (in)
//     s_ready                         stream accept (out)
//     mem_ready                       memory is_ready (in)
//     mem_execute, mem_func,          memory request (out)
//       address1, address2, write_data
//     busy, done, load_error,         status (out)
//       word_count, run_start
// -----------------------------------------------------------------------------
interface nock_image_loader_if #(
  parameter int memory_addr_width = 16,
  parameter int memory_data_width = 32
);
  logic                         load_start;
  logic [memory_addr_width-1:0] base_addr;
  logic                         s_valid;
  logic [memory_data_width-1:0] s_data;
  logic                         s_last;
  logic                         s_ready;
  logic                         mem_ready;
  logic                         mem_execute;
  logic [1:0]                   mem_func;
  logic [memory_addr_width-1:0] address1;
  logic [memory_addr_width-1:0] address2;
  logic [memory_data_width-1:0] write_data;
  logic                         busy;
  logic                         done;
  logic                         load_error;
  logic [memory_addr_width-1:0] word_count;
  logic                         run_start;

  modport master (
    output load_start, base_addr, s_valid, s_data, s_last, mem_ready,
    input  s_ready, mem_execute, mem_func, address1, address2, write_data,
           busy, done, load_error, word_count, run_start
  );

  modport slave (
    input  load_start, base_addr, s_valid, s_data, s_last, mem_ready,
    output s_ready, mem_execute, mem_func, address1, address2, write_data,
           busy, done, load_error, word_count, run_start
  );
endinterface

// File: rtl/nock_image_loader.sv
// -----------------------------------------------------------------------------
// nock_image_loader
//   Streams a noun memory image into memory_unit one word at a time over the
//   shared memory request interface. A clean load ends with a run_start pulse
//   that kicks mem_traversal at start_addr.
//
//   Ports
//     clk  : system clock
//     rst  : asynchronous, active-low reset
//     bus  : nock_image_loader_if.slave (load control, stream, memory port,
//            status)
//
//   Optional feature (macro NOCK_LOADER_CHECKSUM_EN):
//     When the macro is defined, the s_last word is an XOR check word. It is
//     not written to memory. It is compared against the XOR of every word
//     written, and a mismatch sets load_error and suppresses run_start.
//     When the macro is undefined, s_last only marks the final data word.
//
//   Per-word sequence:  RECV -> ISSUE -> WAIT_ACK -> WAIT_RDY
//     ISSUE    : strobe mem_execute in the cycle mem_ready is seen
//     WAIT_ACK : one dead cycle, so the memory can drop is_ready
//     WAIT_RDY : the write is complete once mem_ready returns
// -----------------------------------------------------------------------------
module nock_image_loader #(
  parameter int         memory_addr_width = 16,
  parameter int         memory_data_width = 32,
  parameter logic [1:0] WRITE_FUNC        = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  nock_image_loader_if.slave  bus
);

  localparam int AW = memory_addr_width;
  localparam int DW = memory_data_width;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECV     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_WAIT_RDY = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic [AW-1:0] r_count;
  logic          r_done;
  logic          r_run_start;
  logic          r_error;

  logic          w_busy;
  logic          w_check_word;  // stream word is the trailing check word
  logic          w_sum_ok;      // check word matches the accumulated XOR

`ifdef NOCK_LOADER_CHECKSUM_EN
  logic [DW-1:0] r_xor;

  assign w_check_word = bus.s_last;
  assign w_sum_ok     = (bus.s_data == r_xor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xor <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR)
                 && bus.load_start) begin
      r_xor <= '0;
    end else if (r_state == S_WAIT_RDY && bus.mem_ready) begin
      r_xor <= r_xor ^ r_data;
    end
  end
`else
  assign w_check_word = 1'b0;
  assign w_sum_ok     = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_run_start <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // done/run_start are single-cycle pulses unless a transition below sets them.
      r_done      <= 1'b0;
      r_run_start <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.load_start) begin
            r_state <= S_RECV;
            r_addr  <= bus.base_addr;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end

        S_RECV: begin
          if (bus.s_valid) begin
            if (w_check_word) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_run_start <= w_sum_ok;
              r_error     <= !w_sum_ok;
            end else begin
              r_data  <= bus.s_data;
              r_last  <= bus.s_last;
              r_state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (bus.mem_ready) begin
            r_state <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          r_state <= S_WAIT_RDY;
        end

        S_WAIT_RDY: begin
          if (bus.mem_ready) begin
            r_count <= r_count + AW'(1);
            if (r_last) begin
              r_addr      <= r_addr + AW'(1);
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_run_start <= 1'b1;  // r_error is always clear on this path
            end else if (&r_addr) begin
              // There is another word to load, but the address space is full.
              // Stop here so that no write wraps to address 0.
              r_state <= S_ERROR;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_state <= S_RECV;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy = (r_state == S_RECV)     || (r_state == S_ISSUE) ||
                  (r_state == S_WAIT_ACK) || (r_state == S_WAIT_RDY);

  // s_ready is decoded from the registered state only. It never depends on s_valid.
  assign bus.s_ready     = (r_state == S_RECV);
  assign bus.mem_execute = (r_state == S_ISSUE) && bus.mem_ready;
  assign bus.mem_func    = w_busy ? WRITE_FUNC : 2'b00;
  assign bus.address1    = r_addr;
  assign bus.address2    = '0;
  assign bus.write_data  = r_data;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.load_error  = r_error;
  assign bus.word_count  = r_count;
  assign bus.run_start   = r_run_start;

endmodule

// File: tb/tb_nock_image_loader.sv
// -----------------------------------------------------------------------------
// tb_nock_image_loader
//   Directed bench for nock_image_loader. It uses a 4-bit address and 8-bit
//   data so that the all-ones address is easy to reach. A small RAM model
//   records every write strobe. Expected values are hand-computed. Where the
//   NOCK_LOADER_CHECKSUM_EN build changes the result, the expected value
//   depends on CHK.
// -----------------------------------------------------------------------------
module tb_nock_image_loader;

`ifdef NOCK_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst;

  nock_image_loader_if #(.memory_addr_width(4), .memory_data_width(8)) bus ();

  nock_image_loader #(
    .memory_addr_width(4),
    .memory_data_width(8),
    .WRITE_FUNC       (2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one write per mem_execute strobe that carries the write func.
  logic [7:0] ram [16] = '{default: 8'h00};
  int         n_writes = 0;
  always @(posedge clk) begin
    if (bus.mem_execute && bus.mem_func == 2'b01) begin
      ram[bus.address1] <= bus.write_data;
      n_writes          <= n_writes + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  // This task is called at a negedge and returns at a negedge, with the load
  // running in RECV.
  task automatic start_load(input logic [3:0] base);
    bus.base_addr  = base;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // This task presents one stream word and holds it until an edge where
  // s_ready was high. It returns at the negedge just after that edge.
  task automatic send_word(input logic [7:0] d, input logic l);
    logic ok;
    ok          = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.s_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("send_word_accepted", {31'd0, ok}, 32'd1);
  endtask

  // This task waits, with a bound, for the done pulse. It returns at the
  // negedge where done is high.
  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.done) ok = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", {31'd0, ok}, 32'd1);
  endtask

  int w0;

  initial begin
    rst            = 1'b0;
    bus.load_start = 1'b0;
    bus.base_addr  = '0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.s_last     = 1'b0;
    bus.mem_ready  = 1'b1;

    // ---- Reset --------------------------------------------------------------
    repeat (2) @(negedge clk);
    check("rst_s_ready",     bus.s_ready,     0);
    check("rst_busy",        bus.busy,        0);
    check("rst_done",        bus.done,        0);
    check("rst_run_start",   bus.run_start,   0);
    check("rst_load_error",  bus.load_error,  0);
    check("rst_word_count",  bus.word_count,  0);
    check("rst_mem_execute", bus.mem_execute, 0);
    check("rst_mem_func",    bus.mem_func,    0);
    check("rst_address1",    bus.address1,    0);
    check("rst_write_data",  bus.write_data,  0);
    rst = 1'b1;
    @(negedge clk);

    // ---- Three words at base 1 ----------------------------------------------
    // With the checksum build, 0x33 is the check word: 0x11 ^ 0x22 = 0x33.
    w0 = n_writes;
    start_load(4'h1);
    check("basic_busy_rises", bus.busy, 1);
    check("basic_mem_func",   bus.mem_func, 2'b01);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    wait_done();
    check("basic_run_start",  bus.run_start,  1);
    check("basic_load_error", bus.load_error, 0);
    check("basic_word_count", bus.word_count, CHK ? 2 : 3);
    check("basic_ram1",       ram[1], 8'h11);
    check("basic_ram2",       ram[2], 8'h22);
    check("basic_ram3",       ram[3], CHK ? 8'h00 : 8'h33);
    check("basic_writes",     n_writes - w0, CHK ? 2 : 3);
    @(negedge clk);
    check("basic_done_pulse", bus.done,       0);
    check("basic_run_pulse",  bus.run_start,  0);
    check("basic_busy_low",   bus.busy,       0);
    check("basic_count_hold", bus.word_count, CHK ? 2 : 3);

    // ---- Memory stall in ISSUE; a load_start while busy is ignored ----------
    w0 = n_writes;
    start_load(4'h5);
    bus.mem_ready = 1'b0;
    send_word(8'hA5, !CHK);
    for (int i = 0; i < 5; i++) begin
      check("stall_no_execute", bus.mem_execute, 0);
      check("stall_address",    bus.address1,    4'h5);
      check("stall_data",       bus.write_data,  8'hA5);
      if (i == 1) begin
        bus.base_addr  = 4'h0;
        bus.load_start = 1'b1;
      end else begin
        bus.load_start = 1'b0;
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    #1;
    check("stall_execute_on_ready", bus.mem_execute, 1);
    @(negedge clk);
    check("stall_execute_one_cycle", bus.mem_execute, 0);
    check("stall_address_held",      bus.address1,    4'h5);
    if (CHK) send_word(8'hA5, 1'b1);
    wait_done();
    check("stall_run_start",  bus.run_start,  1);
    check("stall_word_count", bus.word_count, 1);
    check("stall_ram5",       ram[5],         8'hA5);
    check("stall_writes",     n_writes - w0,  1);

    // ---- Address overflow at all-ones ---------------------------------------
    w0 = n_writes;
    start_load(4'hF);
    send_word(8'h77, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h88;
    bus.s_last  = 1'b1;
    wait_done();
    check("ovf_load_error", bus.load_error, 1);
    check("ovf_run_start",  bus.run_start,  0);
    check("ovf_word_count", bus.word_count, 1);
    check("ovf_ramF",       ram[15],        8'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_s_ready_low", bus.s_ready, 0);
      check("ovf_busy_low",    bus.busy,    0);
    end
    check("ovf_error_sticky", bus.load_error, 1);
    check("ovf_no_wrap",      ram[0],         8'h00);
    check("ovf_writes",       n_writes - w0,  1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    // ---- Reset in the middle of WAIT_RDY, then a clean load -----------------
    start_load(4'h2);
    check("rerun_error_cleared", bus.load_error, 0);
    send_word(8'h3C, 1'b0);          // state is ISSUE; the write strobes here
    @(negedge clk);                  // state is WAIT_ACK
    bus.mem_ready = 1'b0;
    @(negedge clk);                  // state is WAIT_RDY, stalled
    check("midrst_busy_before", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_busy",     bus.busy,       0);
    check("midrst_s_ready",  bus.s_ready,    0);
    check("midrst_mem_func", bus.mem_func,   0);
    check("midrst_address1", bus.address1,   0);
    check("midrst_count",    bus.word_count, 0);
    check("midrst_done",     bus.done,       0);
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    w0 = n_writes;
    start_load(4'h8);
    send_word(8'h01, 1'b0);
    send_word(8'h02, !CHK);
    if (CHK) send_word(8'h03, 1'b1);
    wait_done();
    check("after_rst_run_start",  bus.run_start,  1);
    check("after_rst_word_count", bus.word_count, 2);
    check("after_rst_ram8",       ram[8],         8'h01);
    check("after_rst_ram9",       ram[9],         8'h02);
    check("after_rst_writes",     n_writes - w0,  2);

`ifdef NOCK_LOADER_CHECKSUM_EN
    // ---- Checksum good, checksum bad, check word only ------------------------
    start_load(4'hA);
    send_word(8'h05, 1'b0);
    send_word(8'h0A, 1'b0);
    send_word(8'h0F, 1'b1);
    wait_done();
    check("csum_ok_run_start", bus.run_start,  1);
    check("csum_ok_error",     bus.load_error, 0);
    check("csum_ok_count",     bus.word_count, 2);

    start_load(4'hA);
    send_word(8'h05, 1'b0);
    send_word(8'h0A, 1'b0);
    send_word(8'h0E, 1'b1);
    wait_done();
    check("csum_bad_run_start", bus.run_start,  0);
    check("csum_bad_error",     bus.load_error, 1);
    check("csum_bad_count",     bus.word_count, 2);

    w0 = n_writes;
    start_load(4'h3);
    send_word(8'h00, 1'b1);
    wait_done();
    check("csum_alone_run_start", bus.run_start,  1);
    check("csum_alone_count",     bus.word_count, 0);
    check("csum_alone_writes",    n_writes - w0,  0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
